// File: rtl/x_dp_pkg.sv
// Shared constants and op decoding for the multiplier datapath.
package x_dp_pkg;

  localparam int unsigned DefWidth  = 16;
  localparam int unsigned DefNReg   = 5;
  localparam int unsigned DefResIdx = 3;
  localparam int unsigned LdAddrW   = 3;

  typedef enum logic [1:0] {
    OpMove  = 2'd0,
    OpShift = 2'd1,
    OpAdd   = 2'd2,
    OpPpgen = 2'd3
  } op_e;

  // Resolves simultaneous op strobes: ppgen > add > shift > move.
  function automatic op_e op_decode(logic ppgen, logic add, logic shift);
    if (ppgen) return OpPpgen;
    if (add)   return OpAdd;
    if (shift) return OpShift;
    return OpMove;
  endfunction

endpackage

// File: rtl/x_datapath_if.sv
// Control/load/status bundle between the multiplier FSM/host and the datapath.
interface x_datapath_if
  import x_dp_pkg::*;
#(
  parameter int unsigned WIDTH = DefWidth,
  parameter int unsigned NREG  = DefNReg
);
  logic [NREG-1:0]    rd_enA;
  logic [NREG-1:0]    rd_enB;
  logic [NREG-1:0]    wr_en;
  logic               ppgen_en;
  logic               add_en;
  logic               shift_en;
  logic               left_right;
  logic               done;
  logic               ld_en;
  logic [LdAddrW-1:0] ld_addr;
  logic [WIDTH-1:0]   ld_data;
  logic               carry;
  logic [WIDTH-1:0]   result;
  logic               result_valid;
  logic               ld_drop;
  logic               onehot_err;

  modport master (
    output rd_enA, rd_enB, wr_en, ppgen_en, add_en, shift_en, left_right, done,
    output ld_en, ld_addr, ld_data,
    input  carry, result, result_valid, ld_drop, onehot_err
  );

  modport slave (
    input  rd_enA, rd_enB, wr_en, ppgen_en, add_en, shift_en, left_right, done,
    input  ld_en, ld_addr, ld_data,
    output carry, result, result_valid, ld_drop, onehot_err
  );
endinterface

// File: rtl/x_regfile.sv
// NREG x WIDTH register file: two OR-combined one-hot read buses, multi-hot write, host load.
module x_regfile
  import x_dp_pkg::*;
#(
  parameter int unsigned Width  = DefWidth,
  parameter int unsigned NReg   = DefNReg,
  parameter int unsigned ResIdx = DefResIdx
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NReg-1:0]    rd_sel_a_i,
  input  logic [NReg-1:0]    rd_sel_b_i,
  input  logic [NReg-1:0]    wr_en_i,
  input  logic [Width-1:0]   wr_data_i,
  input  logic               ld_we_i,
  input  logic [LdAddrW-1:0] ld_addr_i,
  input  logic [Width-1:0]   ld_data_i,
  output logic [Width-1:0]   rd_a_o,
  output logic [Width-1:0]   rd_b_o,
  output logic [Width-1:0]   res_word_o
);

  logic [Width-1:0] reg_q [NReg];
  logic [Width-1:0] reg_d [NReg];

  always_comb begin
    rd_a_o = '0;
    rd_b_o = '0;
    for (int i = 0; i < NReg; i++) begin
      if (rd_sel_a_i[i]) rd_a_o = rd_a_o | reg_q[i];
      if (rd_sel_b_i[i]) rd_b_o = rd_b_o | reg_q[i];
    end
  end

  // ld_we_i is only asserted by the top when no function-unit write is pending.
  always_comb begin
    reg_d = reg_q;
    for (int i = 0; i < NReg; i++) begin
      if (wr_en_i[i]) begin
        reg_d[i] = wr_data_i;
      end else if (ld_we_i && (ld_addr_i == LdAddrW'(i))) begin
        reg_d[i] = ld_data_i;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      reg_q <= '{default: '0};
    end else begin
      reg_q <= reg_d;
    end
  end

  assign res_word_o = reg_q[ResIdx];

endmodule

// File: rtl/x_datapath.sv
// Multiplier datapath: register file plus ppgen/add/shift unit, carry, result capture and
// load/one-hot status flags, all driven by the FSM over the slave modport.
module x_datapath
  import x_dp_pkg::*;
#(
  parameter int unsigned WIDTH   = DefWidth,
  parameter int unsigned NREG    = DefNReg,
  parameter int unsigned RES_IDX = DefResIdx
) (
  input logic         clk,
  input logic         rst,
  x_datapath_if.slave bus
);

  logic [WIDTH-1:0] bus_a, bus_b, res_word, fu_out;
  logic [WIDTH:0]   sum;
  op_e              op;
  logic             carry_nx;
  logic             wr_any, ld_bad_addr, ld_we;
  logic             multi_a, multi_b;

  logic             carry_q, carry_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             result_valid_q, result_valid_d;
  logic             ld_drop_q, ld_drop_d;
  logic             onehot_err_q, onehot_err_d;

  assign wr_any      = |bus.wr_en;
  assign ld_bad_addr = 32'(bus.ld_addr) >= NREG;
  assign ld_we       = bus.ld_en && !wr_any && !ld_bad_addr;

  // x & (x-1) is nonzero exactly when more than one bit is set.
  assign multi_a = |(bus.rd_enA & (bus.rd_enA - NREG'(1)));
  assign multi_b = |(bus.rd_enB & (bus.rd_enB - NREG'(1)));

  x_regfile #(
    .Width (WIDTH),
    .NReg  (NREG),
    .ResIdx(RES_IDX)
  ) u_regfile (
    .clk       (clk),
    .rst       (rst),
    .rd_sel_a_i(bus.rd_enA),
    .rd_sel_b_i(bus.rd_enB),
    .wr_en_i   (bus.wr_en),
    .wr_data_i (fu_out),
    .ld_we_i   (ld_we),
    .ld_addr_i (bus.ld_addr),
    .ld_data_i (bus.ld_data),
    .rd_a_o    (bus_a),
    .rd_b_o    (bus_b),
    .res_word_o(res_word)
  );

  assign op  = op_decode(bus.ppgen_en, bus.add_en, bus.shift_en);
  assign sum = {1'b0, bus_a} + {1'b0, bus_b};

  always_comb begin
    fu_out   = bus_a;
    carry_nx = carry_q;
    unique case (op)
      OpPpgen: fu_out = bus_b[0] ? bus_a : '0;
      OpAdd:   {carry_nx, fu_out} = sum;
      OpShift: begin
        if (bus.left_right) begin
          fu_out   = {bus_a[WIDTH-2:0], 1'b0};
          carry_nx = bus_a[WIDTH-1];
        end else begin
          fu_out   = {1'b0, bus_a[WIDTH-1:1]};
          carry_nx = bus_a[0];
        end
      end
      OpMove:  ;
      default: ;
    endcase
  end

  always_comb begin
    carry_d        = wr_any ? carry_nx : carry_q;
    result_d       = bus.done ? res_word : result_q;
    result_valid_d = bus.done;
    ld_drop_d      = bus.ld_en && (wr_any || ld_bad_addr);
    onehot_err_d   = onehot_err_q || multi_a || multi_b;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      carry_q        <= 1'b0;
      result_q       <= '0;
      result_valid_q <= 1'b0;
      ld_drop_q      <= 1'b0;
      onehot_err_q   <= 1'b0;
    end else begin
      carry_q        <= carry_d;
      result_q       <= result_d;
      result_valid_q <= result_valid_d;
      ld_drop_q      <= ld_drop_d;
      onehot_err_q   <= onehot_err_d;
    end
  end

  assign bus.carry        = carry_q;
  assign bus.result       = result_q;
  assign bus.result_valid = result_valid_q;
  assign bus.ld_drop      = ld_drop_q;
  assign bus.onehot_err   = onehot_err_q;

endmodule
